// File: rtl/mem_io_responder_pkg.sv
// Shared constants and target decode type for the memory-side responder.
// The MEM_BOUNDS_CHECK_EN build adds the out-of-range target and the bus_error output.
package mem_io_responder_pkg;

    localparam int BYTE = 8;

    localparam logic [1:0] IO_PAGE      = 2'b11;
    localparam logic [2:0] IO_UART_ADDR = 3'h0;
    localparam logic [2:0] IO_CLK_ADDR  = 3'h4;

    typedef enum logic [1:0] {
        TGT_RAM = 2'd0,
        TGT_IO  = 2'd1,
        TGT_OOR = 2'd2
    } target_e;

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte-wide circular FIFO. A push while full and a pop while empty are ignored.
// data_out reads as zero while the FIFO is empty.
module byte_fifo
    import mem_io_responder_pkg::*;
#(
    parameter int DEPTH_LOG = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 push,
    input  logic                 pop,
    input  logic [BYTE-1:0]      data_in,
    output logic [BYTE-1:0]      data_out,
    output logic [DEPTH_LOG:0]   count,
    output logic                 empty,
    output logic                 full
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] COUNT_FULL = (DEPTH_LOG + 1)'(DEPTH);

    logic [BYTE-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic                 do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == COUNT_FULL);
    assign count    = count_q;
    assign data_out = empty ? '0 : mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define the contents.
    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_ptr_q] <= data_in;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder: 128KB RAM plus an I/O page (UART FIFOs, cycle counter, stop strobe).
// Define MEM_BOUNDS_CHECK_EN to trap out-of-range RAM accesses on a sticky bus_error output.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH_LOG   = 3,
    parameter int RX_DEPTH_LOG   = 3
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic [31:0]     mem_a,
    input  logic            mem_wr,
    input  logic [7:0]      mem_dout,
    output logic [7:0]      mem_din,
    output logic            io_buffer_full,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic            program_stop
`ifdef MEM_BOUNDS_CHECK_EN
    ,
    output logic            bus_error
`endif
);

    localparam logic [TX_DEPTH_LOG:0] TX_NEAR_FULL = (TX_DEPTH_LOG + 1)'((1 << TX_DEPTH_LOG) - 1);

    logic [BYTE-1:0] ram [1 << RAM_ADDR_WIDTH];

    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [2:0]                io_sel;
    target_e                   tgt;
    logic                      bus_rd, bus_wr;

    logic [BYTE-1:0] mem_din_q, mem_din_d;
    logic [31:0]     cycle_cnt_q, cycle_cnt_d;
    logic [31:0]     snapshot_q, snapshot_d;
    logic            program_stop_q, program_stop_d;
    logic            io_buffer_full_q, io_buffer_full_d;

    logic                  tx_push, tx_pop, tx_empty, tx_full;
    logic [BYTE-1:0]       tx_push_data;
    logic [TX_DEPTH_LOG:0] tx_count, tx_count_next;
    logic                  rx_pop, rx_empty;
    logic [BYTE-1:0]       rx_head;
    logic [RX_DEPTH_LOG:0] unused_rx_count;
    logic                  unused_rx_full;

    assign ram_addr = mem_a[RAM_ADDR_WIDTH-1:0];
    assign io_sel   = mem_a[2:0];
    assign bus_rd   = rdy_in && !mem_wr;
    assign bus_wr   = rdy_in && mem_wr;

    always_comb begin
        tgt = TGT_RAM;
        if (mem_a[17:16] == IO_PAGE) tgt = TGT_IO;
`ifdef MEM_BOUNDS_CHECK_EN
        else if (mem_a[17:16] == 2'b10 || mem_a[31:18] != '0) tgt = TGT_OOR;
`endif
    end

`ifdef MEM_BOUNDS_CHECK_EN
    logic bus_error_q, bus_error_d;
    assign bus_error = bus_error_q;
`else
    logic unused_hi_addr;
    assign unused_hi_addr = ^mem_a[31:18];
`endif

    always_ff @(posedge clk_in) begin
        if (bus_wr && tgt == TGT_RAM) ram[ram_addr] <= mem_dout;
    end

    always_comb begin
        mem_din_d      = mem_din_q;
        snapshot_d     = snapshot_q;
        cycle_cnt_d    = cycle_cnt_q + 32'd1;
        program_stop_d = 1'b0;
        tx_push        = 1'b0;
        tx_push_data   = mem_dout;
        rx_pop         = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
        bus_error_d    = bus_error_q;
        if ((bus_rd || bus_wr) && tgt == TGT_OOR) bus_error_d = 1'b1;
`endif
        if (bus_rd) begin
            case (tgt)
                TGT_RAM: mem_din_d = ram[ram_addr];
                TGT_IO: begin
                    case (io_sel)
                        IO_UART_ADDR: begin
                            rx_pop    = 1'b1;
                            mem_din_d = rx_head;
                        end
                        // Reading byte 0 refreshes the snapshot so bytes 1-3 stay coherent.
                        IO_CLK_ADDR: begin
                            snapshot_d = cycle_cnt_q;
                            mem_din_d  = cycle_cnt_q[7:0];
                        end
                        3'h5:    mem_din_d = snapshot_q[15:8];
                        3'h6:    mem_din_d = snapshot_q[23:16];
                        3'h7:    mem_din_d = snapshot_q[31:24];
                        default: mem_din_d = '0;
                    endcase
                end
                default: mem_din_d = 8'hFF;
            endcase
        end
        if (bus_wr && tgt == TGT_IO) begin
            if (io_sel == IO_UART_ADDR) begin
                tx_push = (mem_dout != '0);
            end else if (io_sel == IO_CLK_ADDR) begin
                program_stop_d = 1'b1;
                tx_push        = 1'b1;
                tx_push_data   = '0;
            end
        end
    end

    // Flag near-full one entry early so the CPU's one-cycle gating latency cannot overflow.
    assign tx_pop = !tx_empty && tx_ready;
    always_comb begin
        tx_count_next = tx_count;
        case ({tx_push && !tx_full, tx_pop})
            2'b10:   tx_count_next = tx_count + 1'b1;
            2'b01:   tx_count_next = tx_count - 1'b1;
            default: tx_count_next = tx_count;
        endcase
        io_buffer_full_d = (tx_count_next >= TX_NEAR_FULL);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_din_q        <= '0;
            cycle_cnt_q      <= '0;
            snapshot_q       <= '0;
            program_stop_q   <= 1'b0;
            io_buffer_full_q <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
            bus_error_q      <= 1'b0;
`endif
        end else begin
            mem_din_q        <= mem_din_d;
            cycle_cnt_q      <= cycle_cnt_d;
            snapshot_q       <= snapshot_d;
            program_stop_q   <= program_stop_d;
            io_buffer_full_q <= io_buffer_full_d;
`ifdef MEM_BOUNDS_CHECK_EN
            bus_error_q      <= bus_error_d;
`endif
        end
    end

    byte_fifo #(.DEPTH_LOG(TX_DEPTH_LOG)) u_tx_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push     (tx_push),
        .pop      (tx_pop),
        .data_in  (tx_push_data),
        .data_out (tx_data),
        .count    (tx_count),
        .empty    (tx_empty),
        .full     (tx_full)
    );

    byte_fifo #(.DEPTH_LOG(RX_DEPTH_LOG)) u_rx_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push     (rx_valid),
        .pop      (rx_pop),
        .data_in  (rx_data),
        .data_out (rx_head),
        .count    (unused_rx_count),
        .empty    (rx_empty),
        .full     (unused_rx_full)
    );

    assign mem_din        = mem_din_q;
    assign io_buffer_full = io_buffer_full_q;
    assign tx_valid       = !tx_empty;
    assign program_stop   = program_stop_q;

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the CPU's byte-wide memory bus.
- Services every bus cycle against one of two targets:
  - 128KB RAM.
  - I/O page selected by mem_a[17:16]==2'b11:
    - UART TX FIFO.
    - UART RX FIFO.
    - Cycle counter.
    - Program-stop strobe.
- Drives io_buffer_full back to the CPU. Sits between the CPU and the UART/host interface.

Parameters:
- RAM_ADDR_WIDTH, 17, byte address bits of RAM (2^17 = 128KB).
- TX_DEPTH_LOG, 3, log2 of TX FIFO entries.
- RX_DEPTH_LOG, 3, log2 of RX FIFO entries.

Ports:
- clk_in  input  1  single clock.
- rst_in  input  1  reset, asynchronous, active-high.
- rdy_in  input  1  bus enable; low = freeze bus-side state.
- mem_a  input  32  CPU byte address.
- mem_wr  input  1  1 = write, 0 = read; sampled every cycle.
- mem_dout  input  8  CPU write data.
- mem_din  output  8  read data, valid the cycle after the address.
- io_buffer_full  output  1  TX FIFO cannot accept a write this cycle.
- tx_data  output  8  byte to UART transmitter.
- tx_valid  output  1  TX FIFO non-empty.
- tx_ready  input  1  UART accepts tx_data this cycle.
- rx_data  input  8  byte from UART receiver.
- rx_valid  input  1  push rx_data into RX FIFO.
- program_stop  output  1  one-cycle pulse on stop write.

Behaviour:
- Reset: clock and reset as decided: single clock clk_in; rst_in asynchronous, active-high.
  - mem_din=0, io_buffer_full=0, tx_valid=0, program_stop=0.
  - FIFO pointers/counts=0, cycle counter=0, snapshot=0.
  - RAM contents not reset.
  - Reset mid-transfer discards both FIFOs and any pending read data.
- Bus decode, every cycle with rdy_in=1:
  - mem_a[17:16]!=2'b11: RAM at mem_a[RAM_ADDR_WIDTH-1:0].
  - mem_a[17:16]==2'b11: I/O, decoded on mem_a[2:0].
- RAM access:
  - Write: stored at the clock edge.
  - Read: registered; mem_din shows RAM[addr] the next cycle.
  - Read-after-write to the same address in consecutive cycles returns the new value.
- I/O write 0x30000:
  - Nonzero byte: pushes to the TX FIFO.
  - 0x00: ignored.
  - If the TX FIFO is full, the write is dropped. CPU gates on io_buffer_full, so this is a protocol violation.
- I/O write 0x30004: program_stop=1 for the next cycle; also pushes 0x00 into the TX FIFO if not full.
- I/O read 0x30000:
  - RX FIFO non-empty: pops the head; mem_din=head next cycle.
  - RX FIFO empty: mem_din=0x00 next cycle.
- I/O read 0x30004..0x30007:
  - A read of 0x30004 latches the 32-bit cycle counter into the snapshot and returns snapshot[7:0].
  - 0x30005/6/7 return snapshot bytes 1/2/3 (little-endian), so multi-byte reads are coherent.
- Other I/O addresses: reads return 0, writes ignored.
- Cycle counter:
  - Increments every clk_in cycle after reset, independent of rdy_in.
  - 32-bit, wraps 0xFFFFFFFF to 0.
- rdy_in=0:
  - No RAM write, no FIFO push/pop from the bus, mem_din holds.
  - UART-side TX pop and RX push continue.
- FIFOs:
  - Circular buffers with a count of width DEPTH_LOG+1. Full = count==2^DEPTH_LOG; empty = count==0.
  - Simultaneous push and pop: count unchanged. Pointers wrap mod 2^DEPTH_LOG.
  - TX: tx_data=head, tx_valid=!empty. Pop when tx_valid&&tx_ready.
  - RX: push when rx_valid and not full; when full, the byte is dropped.
  - RX push and CPU pop in the same cycle both take effect. If empty, the pop sees empty and returns 0.
- io_buffer_full:
  - Registered: 1 when TX count >= 2^TX_DEPTH_LOG-1 after this cycle's updates.
  - This gives one slot of margin for the CPU's one-cycle gating latency.

Optional Feature:
- MEM_BOUNDS_CHECK_EN defined:
  - RAM access with mem_a[17:16]==2'b10 or mem_a[31:18]!=0 is out-of-range.
  - Write suppressed; read returns 0xFF.
  - Sticky output bus_error (1 bit, reset 0) is set until reset.
- Undefined:
  - No bus_error port.
  - Upper bits ignored; addresses alias onto RAM via mem_a[RAM_ADDR_WIDTH-1:0].

Decomposition:
- Shared package holds:
  - IO_PAGE=2'b11.
  - IO_UART_ADDR=3'h0, IO_CLK_ADDR=3'h4.
  - BYTE width constant.
- One sub-module: byte_fifo (parameter DEPTH_LOG; push/pop/data_in/data_out/count/empty/full). Instantiated twice, for TX and RX.
- RAM stays inline as an inferred block RAM.

Test Plan:
- RAM:
  - Write 0xA5 @0x00010 then read 0x00010 next cycle -> mem_din=0xA5 one cycle after read address.
  - Read 0x1FFFF after writing 0x3C there -> 0x3C.
- TX:
  - Write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx_data sequence 0x41, 0x42 only.
  - With tx_ready=0 and TX_DEPTH_LOG=3, after 7 writes io_buffer_full=1; 8th write accepted; 9th dropped.
- RX:
  - rx_valid pulses 0x11, 0x22, then two reads of 0x30000 -> mem_din 0x11, 0x22.
  - Third read -> 0x00.
- Counter: hold 100 cycles after reset, read 0x30004..0x30007 back-to-back.
  - Returned bytes form one snapshot, = cycle index of the 0x30004 read.
  - Later reads are unaffected until 0x30004 is re-read.
- Stop and reset:
  - Write any byte to 0x30004 -> program_stop high exactly one cycle; 0x00 appears on tx_data.
  - Assert rst_in asynchronously mid-burst -> all outputs 0 immediately.
- rdy_in=0 during RAM write to 0x20 -> RAM[0x20] unchanged; mem_din held.
- MEM_BOUNDS_CHECK_EN: write 0x20000 -> bus_error=1, read returns 0xFF.
